store_buffer: RTL

//  Posted-write buffer between the 16-bit core's data port (writedata/dataadr/memwrite) and data memory.

---
 rtl/store_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer between core data port and memory
// Optional load forwarding from pending stores: define STORE_BUFFER_FORWARD_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_memwrite,
    input  logic                     cpu_memread,
    input  logic [AW-1:0]            cpu_dataadr,
    input  logic [DW-1:0]            cpu_writedata,
    output logic [DW-1:0]            cpu_readdata,
    output logic                     stall,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    adr_q  [DEPTH];
    logic [AW-1:0]    adr_d  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic          full, empty;
    logic          enq, retire;
    logic          store_full, load_req;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign enq        = cpu_memwrite & ~full;
    assign retire     = ~empty & mem_ready;
    assign store_full = cpu_memwrite & full;
    // A simultaneous load is dropped: the store owns the port this cycle.
    assign load_req   = cpu_memread & ~cpu_memwrite;
    assign occupancy  = count_q;

`ifdef STORE_BUFFER_FORWARD_EN
    logic [PW-1:0] scan_idx;

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && (adr_q[scan_idx] == cpu_dataadr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[scan_idx];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            adr_d[i]  = adr_q[i];
            data_d[i] = data_q[i];
        end
        if (enq) begin
            adr_d[tail_q]   = cpu_dataadr;
            data_d[tail_q]  = cpu_writedata;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (enq && !retire) begin
            count_d = count_q + CW'(1);
        end else if (!enq && retire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= adr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Outputs are forced quiet while reset is held, even before any clock edge.
    always_comb begin
        stall        = 1'b0;
        mem_we       = 1'b0;
        mem_adr      = '0;
        mem_wdata    = '0;
        cpu_readdata = '0;
        if (reset) begin
            mem_we    = ~empty;
            mem_adr   = empty ? cpu_dataadr : adr_q[head_q];
            mem_wdata = empty ? '0 : data_q[head_q];
            stall     = store_full | (load_req & ~empty & ~fwd_hit);
            if (load_req) begin
                if (fwd_hit) begin
                    cpu_readdata = fwd_data;
                end else if (empty) begin
                    cpu_readdata = mem_rdata;
                end
            end
        end
    end

endmodule
